// File: rtl/gamepad_pmod_tx.sv
// -----------------------------------------------------------------------------
// gamepad_pmod_tx
//
// Transmitter end of the single-controller gamepad Pmod link. It serializes a
// 12-bit button word onto pmod_latch / pmod_clk / pmod_data with the same
// waveform the Pmod itself produces, so an in-chip gamepad_pmod_single
// receiver can be driven for loopback self-test or from generated stimulus.
//
// Frame: LOAD (1 clk), 12 x {SHIFT_LO, SHIFT_HI} (CLK_DIV clks each),
//        LATCH (CLK_DIV clks), GAP (FRAME_GAP clks).
//        Continuous period = 1 + 25*CLK_DIV + FRAME_GAP clocks.
//
// Parameters:
//   CLK_DIV    system clocks per pmod_clk half-period and per latch pulse (>=1)
//   FRAME_GAP  idle clocks after the latch pulse before the next frame (>=1)
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   enable      level; while high, frames are sent back-to-back
//   buttons     {b,y,select,start,up,down,left,right,a,x,l,r}, bit 11 = b
//   present     0 = emulate an absent controller (all bits read as 1)
//   pmod_latch  latch strobe, active high
//   pmod_clk    shift clock; receiver samples pmod_data on its rising edge
//   pmod_data   serial data, MSB (buttons[11]) first
//   busy        high from LOAD through GAP
//   frame_done  one-cycle pulse in the first GAP cycle
// -----------------------------------------------------------------------------
module gamepad_pmod_tx #(
    parameter int CLK_DIV   = 4,
    parameter int FRAME_GAP = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [11:0] buttons,
    input  logic        present,
    output logic        pmod_latch,
    output logic        pmod_clk,
    output logic        pmod_data,
    output logic        busy,
    output logic        frame_done
);

    localparam int MAX_LEN = (CLK_DIV > FRAME_GAP) ? CLK_DIV : FRAME_GAP;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(FRAME_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        GAP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  phase_cnt;
    logic [3:0]        bit_cnt;
    // Holds the bits still to be sent after the one currently on pmod_data;
    // the bit being transmitted lives in the pmod_data register itself.
    logic [10:0]       shift_reg;
    logic [11:0]       snap;
    logic              div_end;
    logic              gap_end;

    // An absent controller reads as all ones (pull-ups on the data line).
    assign snap    = present ? buttons : 12'hFFF;
    assign div_end = (phase_cnt == DIV_LAST);
    assign gap_end = (phase_cnt == GAP_LAST);

    // -------------------------------------------------------------------------
    // Control FSM and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            bit_cnt    <= '0;
            pmod_latch <= 1'b0;
            pmod_clk   <= 1'b0;
            pmod_data  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    pmod_latch <= 1'b0;
                    pmod_clk   <= 1'b0;
                    pmod_data  <= 1'b0;
                    phase_cnt  <= '0;
                    if (enable) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                LOAD: begin
                    bit_cnt   <= 4'd11;
                    busy      <= 1'b1;
                    pmod_clk  <= 1'b0;
                    pmod_data <= snap[11];
                    phase_cnt <= '0;
                    state     <= SHIFT_LO;
                end

                SHIFT_LO: begin
                    if (div_end) begin
                        phase_cnt <= '0;
                        pmod_clk  <= 1'b1;
                        state     <= SHIFT_HI;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                SHIFT_HI: begin
                    if (div_end) begin
                        phase_cnt <= '0;
                        pmod_clk  <= 1'b0;
                        if (bit_cnt == 4'd0) begin
                            pmod_data  <= 1'b0;
                            pmod_latch <= 1'b1;
                            state      <= LATCH;
                        end else begin
                            pmod_data <= shift_reg[10];
                            bit_cnt   <= bit_cnt - 4'd1;
                            state     <= SHIFT_LO;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                LATCH: begin
                    if (div_end) begin
                        phase_cnt  <= '0;
                        pmod_latch <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= GAP;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                GAP: begin
                    if (gap_end) begin
                        phase_cnt <= '0;
                        if (enable) begin
                            state <= LOAD;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state      <= IDLE;
                    phase_cnt  <= '0;
                    bit_cnt    <= '0;
                    pmod_latch <= 1'b0;
                    pmod_clk   <= 1'b0;
                    pmod_data  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Button snapshot / shift path (data only, reloaded every LOAD)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            shift_reg <= snap[10:0];
        end else if (state == SHIFT_HI && div_end && bit_cnt != 4'd0) begin
            shift_reg <= {shift_reg[9:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
module tb_gamepad_pmod_tx;

    localparam int CLK_DIV   = 4;
    localparam int FRAME_GAP = 64;
    localparam int PERIOD    = 1 + 25 * CLK_DIV + FRAME_GAP;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enable  = 1'b0;
    logic        present = 1'b0;
    logic [11:0] buttons = 12'h000;
    logic        pmod_latch;
    logic        pmod_clk;
    logic        pmod_data;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    gamepad_pmod_tx #(
        .CLK_DIV   (CLK_DIV),
        .FRAME_GAP (FRAME_GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .buttons    (buttons),
        .present    (present),
        .pmod_latch (pmod_latch),
        .pmod_clk   (pmod_clk),
        .pmod_data  (pmod_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int          checks    = 0;
    int          failures  = 0;
    logic [11:0] exp_q[$];
    int          cyc       = 0;
    int          edge_cnt  = 0;
    int          latch_cnt = 0;
    int          done_cnt  = 0;
    int          last_edge = 0;
    int          latch_start = 0;
    logic [11:0] rx        = 12'h000;
    logic [11:0] last_word = 12'h000;
    logic        prev_clk  = 1'b0;
    logic        prev_latch = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Receiver model + scoreboard consumer: behaves like the Pmod receiver,
    // shifting pmod_data on rising pmod_clk and capturing on the latch.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            edge_cnt   = 0;
            rx         = 12'h000;
            prev_clk   = 1'b0;
            prev_latch = 1'b0;
        end else begin
            if (pmod_clk && !prev_clk) begin
                if (edge_cnt > 0)
                    chk("clk_edge_spacing", cyc - last_edge, 2 * CLK_DIV);
                last_edge = cyc;
                rx = {rx[10:0], pmod_data};
                edge_cnt++;
            end
            if (pmod_latch && !prev_latch) begin
                latch_cnt++;
                latch_start = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame actual=0x%0h required=no_frame", rx);
                end else begin
                    chk("frame_word", rx, exp_q.pop_front());
                    chk("frame_edges", edge_cnt, 12);
                end
                last_word = rx;
                edge_cnt  = 0;
            end
            if (!pmod_latch && prev_latch)
                chk("latch_width", cyc - latch_start, CLK_DIV);
            if (frame_done)
                done_cnt++;
            prev_clk   = pmod_clk;
            prev_latch = pmod_latch;
        end
    end

    task automatic pulse_enable();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_done(output int t);
        t = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (frame_done) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("frame_done_timeout", 0, 1);
    endtask

    task automatic idle_after_done();
        int k;
        k = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            k++;
            if (!busy) break;
        end
        chk("busy_low_after_done", k, FRAME_GAP);
    endtask

    task automatic wait_edges(input int n);
        bool_wait : begin
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (edge_cnt >= n) disable bool_wait;
            end
            chk("edge_wait_timeout", 0, 1);
        end
    endtask

    initial begin
        int t1, t2, t3, t4, d_latch, d_done;

        // Reset with enable high and all buttons pressed
        rst_n   = 1'b0;
        enable  = 1'b1;
        buttons = 12'hFFF;
        present = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {pmod_latch, pmod_clk, pmod_data, busy, frame_done}, 5'b0);
        exp_q.push_back(12'hFFF);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_release", busy, 1);
        enable = 1'b0;
        wait_done(t1);
        idle_after_done();

        // Single frame, 12'hA5C
        buttons = 12'hA5C;
        present = 1'b1;
        exp_q.push_back(12'hA5C);
        d_done = done_cnt;
        pulse_enable();
        wait_done(t1);
        idle_after_done();
        chk("frame_done_once", done_cnt - d_done, 1);

        // Absent controller
        buttons = 12'h000;
        present = 1'b0;
        exp_q.push_back(12'hFFF);
        pulse_enable();
        wait_done(t1);
        idle_after_done();

        // Snapshot stability: change buttons during bit 5
        buttons = 12'h800;
        present = 1'b1;
        exp_q.push_back(12'h800);
        pulse_enable();
        wait_edges(7);
        buttons = 12'h001;
        wait_done(t1);
        idle_after_done();
        exp_q.push_back(12'h001);
        pulse_enable();
        wait_done(t1);
        idle_after_done();

        // Continuous frames, then stop mid-shift of frame 4
        buttons = 12'h3C3;
        repeat (4) exp_q.push_back(12'h3C3);
        @(negedge clk);
        enable = 1'b1;
        wait_done(t1);
        wait_done(t2);
        wait_done(t3);
        chk("period_1_2", t2 - t1, PERIOD);
        chk("period_2_3", t3 - t2, PERIOD);
        wait_edges(3);
        enable = 1'b0;
        wait_done(t4);
        chk("period_3_4", t4 - t3, PERIOD);
        idle_after_done();
        d_latch = latch_cnt;
        repeat (400) @(negedge clk);
        chk("no_frame5", latch_cnt, d_latch);
        chk("idle_busy", busy, 0);

        // Loopback: up button only
        buttons = 12'h080;
        present = 1'b1;
        exp_q.push_back(12'h080);
        pulse_enable();
        wait_done(t1);
        idle_after_done();
        chk("loopback_up", last_word[7], 1);
        chk("loopback_others", last_word & 12'hF7F, 0);
        chk("loopback_present", (last_word != 12'hFFF), 1);

        // Async reset mid-shift: no latch pulse for the aborted frame
        pulse_enable();
        wait_edges(5);
        d_latch = latch_cnt;
        d_done  = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {pmod_latch, pmod_clk, pmod_data, busy, frame_done}, 5'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        chk("aborted_no_latch", latch_cnt, d_latch);
        chk("aborted_no_done", done_cnt, d_done);

        // Restart after reset starts again from bit 11
        buttons = 12'h5A3;
        exp_q.push_back(12'h5A3);
        pulse_enable();
        wait_done(t1);
        idle_after_done();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
